mnist_batch_ctrl: RTL and testbench
===================================

Name: mnist_batch_ctrl

Overview:
- Host-side sequencer that drives the inference engine's start/done handshake (mnist_top: start in, done and 4-bit predicted_class out) over a batch of stored images.
- Per image: issues one start pulse, waits for done, captures the predicted class and compares it with the label from the label ROM.
- Accumulates processed and correct counts and aborts the batch on a hung engine.
- Sits between the board-level control/status logic and mnist_top, replacing the bench-driven start sequence.

Parameters:
- NUM_IMAGES, 16, number of images in a batch (1..2^IDX_W).
- IDX_W, 4, image index width; must satisfy 2^IDX_W >= NUM_IMAGES.
- TIMEOUT_CYCLES, 200000, maximum cycles allowed in WAIT per image before abort.
- TO_W, 18, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  rising-edge system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  single-cycle request to start a batch; ignored while busy.
- img_idx  out  IDX_W  current image index; selects the image buffer and the label ROM entry.
- label_in  in  4  ground-truth label for img_idx; must be valid 1 cycle after img_idx changes.
- infer_start  out  1  one-cycle start pulse to the engine.
- infer_done  in  1  engine completion; pulse or level, rising-edge detected.
- infer_class  in  4  engine prediction; valid while infer_done is high.
- result_valid  out  1  one-cycle strobe per completed image.
- result_class  out  4  captured prediction.
- result_hit  out  1  1 when result_class equals label_in.
- processed_cnt  out  IDX_W+1  images completed in the current batch.
- correct_cnt  out  IDX_W+1  correct predictions in the current batch.
- busy  out  1  high from ISSUE through FINISH.
- batch_done  out  1  one-cycle strobe at the end of a batch.
- timeout_err  out  1  sticky; set on abort, cleared by the next accepted run.

Behaviour:
- Reset: all outputs 0, state IDLE, done_q=0, timeout counter 0.
- done_q registers infer_done every cycle. done_rise = infer_done & ~done_q.
- States: IDLE, ISSUE, WAIT, CHECK, FINISH.
- IDLE, on run: clear img_idx, processed_cnt, correct_cnt and timeout_err; go to ISSUE.
- ISSUE (1 cycle):
  - infer_start=1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - done_rise: capture infer_class into result_class; go to CHECK.
  - Otherwise, counter == TIMEOUT_CYCLES-1: set timeout_err; go to FINISH without a result.
  - Otherwise: increment the counter.
  - A done level still high from a previous image is never accepted; only a rising edge counts.
  - A done_rise in the cycle the counter hits its limit counts as success (done has priority).
- CHECK (1 cycle):
  - result_valid=1 and result_hit=(result_class==label_in).
  - processed_cnt+1; correct_cnt+1 if hit.
  - If img_idx==NUM_IMAGES-1, go to FINISH; else img_idx+1 and go to ISSUE.
- FINISH (1 cycle): batch_done=1; go to IDLE. Counts and timeout_err hold until the next run.
- Start-to-start latency per image is the engine latency + 3 cycles. The minimum engine latency is 1 cycle after the start pulse.
- run asserted while busy is dropped (no queueing). run in the same cycle as FINISH is also dropped.
- Asynchronous reset mid-batch returns to IDLE immediately and leaves no pending start pulse.
- Comparisons are unsigned 4-bit. Labels above 9 are compared as-is and can never hit.

Decomposition:
- Shared package mnist_pkg: state enum, CLASS_W=4, NUM_CLASSES=10.
- Sub-module mnist_timeout_cnt: a clearable, saturating up-counter with a terminal-count flag. Used by WAIT and reusable by other engine sequencers.

Test Plan:
- NUM_IMAGES=4, engine model returns classes {3,7,1,9} at 50 cycles, labels {3,7,2,9} -> 4 result_valid strobes, hits 1,1,0,1, correct_cnt=3, processed_cnt=4, one batch_done, timeout_err=0.
- Engine holds infer_done high for 20 cycles per image -> exactly one capture per image; infer_start pulses spaced engine latency + 3 cycles.
- Engine never responds, TIMEOUT_CYCLES=100 -> timeout_err=1 exactly 100 cycles after WAIT entry, batch_done strobe, processed_cnt=0, no result_valid.
- run pulsed mid-batch -> ignored; counts and img_idx unchanged. A second run after FINISH clears timeout_err and counts.
- Engine latency 1 cycle and done_rise coincident with the timeout limit -> both accepted as success.
- rst_n asserted in WAIT with infer_done high -> all outputs 0 immediately. After release, the stale done level is not accepted until a new run and a new rising edge.

Source files
------------

// File: rtl/mnist_pkg.sv
// mnist_pkg: shared types and constants for the MNIST batch sequencer
package mnist_pkg;
  localparam int CLASS_W     = 4;
  localparam int NUM_CLASSES = 10;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FINISH} state_e;
endpackage

// File: rtl/mnist_timeout_cnt.sv
// mnist_timeout_cnt: clearable up-counter that saturates at LIMIT-1 and flags terminal count
module mnist_timeout_cnt #(
  parameter int LIMIT = 200000,
  parameter int W     = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tc    = cnt_q == W'(LIMIT - 1);
    cnt_d = clr ? '0 : (en && !tc) ? cnt_q + W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mnist_batch_ctrl.sv
// mnist_batch_ctrl: sequences start/done handshakes over a batch of images and scores predictions
module mnist_batch_ctrl
  import mnist_pkg::*;
#(
  parameter int NUM_IMAGES     = 16,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [IDX_W-1:0]   img_idx,
  input  logic [CLASS_W-1:0] label_in,
  output logic               infer_start,
  input  logic               infer_done,
  input  logic [CLASS_W-1:0] infer_class,
  output logic               result_valid,
  output logic [CLASS_W-1:0] result_class,
  output logic               result_hit,
  output logic [IDX_W:0]     processed_cnt,
  output logic [IDX_W:0]     correct_cnt,
  output logic               busy,
  output logic               batch_done,
  output logic               timeout_err
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CLASS_W-1:0] rclass_q, rclass_d;
  logic [IDX_W:0]     proc_q, proc_d, corr_q, corr_d;
  logic start_q, start_d, rvalid_q, rvalid_d, rhit_q, rhit_d;
  logic busy_q, busy_d, bdone_q, bdone_d, terr_q, terr_d;
  logic done_q, done_rise, hit, last, to_tc;

  mnist_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES), .W(TO_W)) u_to (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == S_ISSUE),
    .en   (state_q == S_WAIT),
    .tc   (to_tc)
  );

  always_comb begin
    done_rise = infer_done & ~done_q;
    hit       = infer_class == label_in;
    last      = idx_q == IDX_W'(NUM_IMAGES - 1);
    state_d   = state_q;
    idx_d     = idx_q;
    rclass_d  = rclass_q;
    rhit_d    = rhit_q;
    proc_d    = proc_q;
    corr_d    = corr_q;
    terr_d    = terr_q;
    rvalid_d  = 1'b0;
    bdone_d   = 1'b0;
    // The start pulse leaves the register one cycle after ISSUE, so WAIT begins with it
    start_d   = state_q == S_ISSUE;
    case (state_q)
      S_IDLE: if (run) begin
        state_d = S_ISSUE;
        idx_d   = '0;
        proc_d  = '0;
        corr_d  = '0;
        terr_d  = 1'b0;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (done_rise) begin
        state_d  = S_CHECK;
        rclass_d = infer_class;
        rhit_d   = hit;
        rvalid_d = 1'b1;
        proc_d   = proc_q + (IDX_W+1)'(1);
        corr_d   = corr_q + (IDX_W+1)'(hit);
      end else if (to_tc) begin
        state_d = S_FINISH;
        terr_d  = 1'b1;
        bdone_d = 1'b1;
      end
      S_CHECK: begin
        state_d = last ? S_FINISH : S_ISSUE;
        idx_d   = last ? idx_q : idx_q + IDX_W'(1);
        bdone_d = last;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rclass_q <= '0;
      rhit_q   <= 1'b0;
      proc_q   <= '0;
      corr_q   <= '0;
      terr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      bdone_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rclass_q <= rclass_d;
      rhit_q   <= rhit_d;
      proc_q   <= proc_d;
      corr_q   <= corr_d;
      terr_q   <= terr_d;
      rvalid_q <= rvalid_d;
      bdone_q  <= bdone_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= infer_done;
    end
  end

  assign img_idx       = idx_q;
  assign infer_start   = start_q;
  assign result_valid  = rvalid_q;
  assign result_class  = rclass_q;
  assign result_hit    = rhit_q;
  assign processed_cnt = proc_q;
  assign correct_cnt   = corr_q;
  assign busy          = busy_q;
  assign batch_done    = bdone_q;
  assign timeout_err   = terr_q;
endmodule

// File: tb/tb_mnist_batch_ctrl.sv
// tb_mnist_batch_ctrl: directed checks of the batch sequencer against a latency-programmable engine model
module tb_mnist_batch_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [1:0] img_idx;
  logic [3:0] label_in, infer_class, result_class;
  logic       infer_start, infer_done, result_valid, result_hit, busy, batch_done, timeout_err;
  logic [2:0] processed_cnt, correct_cnt;

  logic [3:0] cls_tab [4];
  logic [3:0] lab_tab [4];
  logic       hit_exp [4];
  int         lat = 0, hold = 1, ecnt = 0, ehold = 0;
  logic       eng_done = 1'b0, man_en = 1'b0, man_done = 1'b0;
  int         cyc = 0, nbd = 0, errors = 0, checks = 0;
  int         st [$];
  logic [3:0] vcls [$];
  logic       vhit [$];

  always #5 clk = ~clk;

  assign infer_done  = man_en ? man_done : eng_done;
  assign infer_class = cls_tab[img_idx];
  assign label_in    = lab_tab[img_idx];

  mnist_batch_ctrl #(.NUM_IMAGES(4), .IDX_W(2), .TIMEOUT_CYCLES(100), .TO_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .img_idx(img_idx), .label_in(label_in),
    .infer_start(infer_start), .infer_done(infer_done), .infer_class(infer_class),
    .result_valid(result_valid), .result_class(result_class), .result_hit(result_hit),
    .processed_cnt(processed_cnt), .correct_cnt(correct_cnt), .busy(busy),
    .batch_done(batch_done), .timeout_err(timeout_err)
  );

  // Engine: done rises lat cycles after the start cycle, held for hold cycles; lat=0 never answers
  initial forever begin
    @(negedge clk);
    if (infer_start) begin
      eng_done = 1'b0;
      ecnt = lat;
    end else if (ecnt > 0) begin
      ecnt--;
      if (ecnt == 0) begin
        eng_done = 1'b1;
        ehold = hold;
      end
    end else if (eng_done) begin
      ehold--;
      if (ehold == 0) eng_done = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (infer_start) st.push_back(cyc);
    if (result_valid) begin
      vcls.push_back(result_class);
      vhit.push_back(result_hit);
    end
    if (batch_done) nbd++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_bd(input int lim);
    int n = 0;
    while (batch_done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("batch_done_wait", batch_done, 1);
  endtask

  task automatic wait_res(input int vb, input int lim);
    int n = 0;
    while (vcls.size() <= vb && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("result_wait", vcls.size() - vb, 1);
  endtask

  // Called in the IDLE cycle right after FINISH of a full successful batch
  task automatic check_batch(input string tag, input int sb, input int vb, input int bb, input int l);
    chk({tag, "_nstart"}, st.size() - sb, 4);
    for (int i = 1; i < 4; i++)
      if (sb + i < st.size()) chk({tag, "_gap"}, st[sb+i] - st[sb+i-1], l + 3);
    chk({tag, "_nvalid"}, vcls.size() - vb, 4);
    for (int i = 0; i < 4; i++)
      if (vb + i < vcls.size()) begin
        chk({tag, "_class"}, vcls[vb+i], cls_tab[i]);
        chk({tag, "_hit"}, vhit[vb+i], hit_exp[i]);
      end
    chk({tag, "_processed"}, processed_cnt, 4);
    chk({tag, "_correct"}, correct_cnt, 3);
    chk({tag, "_timeout"}, timeout_err, 0);
    chk({tag, "_nbatch_done"}, nbd - bb, 1);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int sb, vb, bb, c0, c1, n;
    cls_tab = '{4'd3, 4'd7, 4'd1, 4'd9};
    lab_tab = '{4'd3, 4'd7, 4'd2, 4'd9};
    hit_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_start", infer_start, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_processed", processed_cnt, 0);
    rst_n = 1'b1;
    tick(2);

    // Batch 1: pulsed done, latency 50, plus a run mid-batch and a run during FINISH
    lat = 50; hold = 1;
    sb = st.size(); vb = vcls.size(); bb = nbd;
    pulse_run();
    chk("issue_busy", busy, 1);
    wait_res(vb, 200);
    tick(5);
    chk("mid_idx_before", img_idx, 1);
    pulse_run();
    tick(1);
    chk("mid_idx_after", img_idx, 1);
    chk("mid_processed_after", processed_cnt, 1);
    chk("mid_busy", busy, 1);
    wait_bd(400);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    check_batch("b1", sb, vb, bb, 50);
    tick(3);
    chk("finish_run_dropped", busy, 0);

    // Batch 2: done held high for 20 cycles, overlapping the next start
    lat = 50; hold = 20;
    sb = st.size(); vb = vcls.size(); bb = nbd;
    pulse_run();
    wait_bd(400);
    tick(1);
    check_batch("b2", sb, vb, bb, 50);
    tick(30);

    // Engine never answers: abort exactly 100 cycles after WAIT entry
    lat = 0; hold = 1;
    vb = vcls.size();
    pulse_run();
    n = 0;
    while (infer_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("to_start_seen", infer_start, 1);
    c0 = cyc;
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    c1 = cyc;
    chk("to_latency", c1 - c0, 100);
    chk("to_batch_done", batch_done, 1);
    chk("to_processed", processed_cnt, 0);
    chk("to_nvalid", vcls.size() - vb, 0);
    tick(1);
    chk("to_sticky", timeout_err, 1);
    chk("to_busy", busy, 0);

    // Next run clears the error; minimum engine latency
    lat = 1; hold = 1;
    sb = st.size(); vb = vcls.size(); bb = nbd;
    pulse_run();
    chk("rerun_clr_timeout", timeout_err, 0);
    chk("rerun_clr_processed", processed_cnt, 0);
    wait_bd(100);
    tick(1);
    check_batch("b3", sb, vb, bb, 1);

    // done rises exactly on the cycle the counter reaches its limit
    lat = 99; hold = 1;
    sb = st.size(); vb = vcls.size(); bb = nbd;
    pulse_run();
    wait_bd(600);
    tick(1);
    check_batch("b4", sb, vb, bb, 99);

    // One cycle later is a timeout
    lat = 100; hold = 1;
    vb = vcls.size();
    pulse_run();
    wait_bd(300);
    chk("late_timeout", timeout_err, 1);
    chk("late_processed", processed_cnt, 0);
    chk("late_nvalid", vcls.size() - vb, 0);
    tick(5);

    // Asynchronous reset in WAIT of image 1 with done high
    lat = 5; hold = 1;
    vb = vcls.size();
    pulse_run();
    wait_res(vb, 20);
    lat = 0;
    tick(3);
    chk("prerst_idx", img_idx, 1);
    chk("prerst_class", result_class, 3);
    man_done = 1'b1;
    man_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_idx", img_idx, 0);
    chk("arst_processed", processed_cnt, 0);
    chk("arst_correct", correct_cnt, 0);
    chk("arst_class", result_class, 0);
    chk("arst_hit", result_hit, 0);
    chk("arst_start", infer_start, 0);
    tick(3);
    rst_n = 1'b1;
    vb = vcls.size();
    tick(5);
    chk("post_rst_idle", busy, 0);
    pulse_run();
    tick(10);
    chk("stale_busy", busy, 1);
    chk("stale_nvalid", vcls.size() - vb, 0);
    man_done = 1'b0;
    tick(1);
    man_done = 1'b1;
    wait_res(vb, 10);
    chk("fresh_valid", result_valid, 1);
    chk("fresh_class", result_class, 3);
    chk("fresh_hit", result_hit, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
